// File: rtl/counter_clk_down.sv
// MM:SS countdown timer for the clock's timer mode. Decrements once per tick
// strobe while running, pulses o_borrow on each seconds wrap and o_done at 00:00.
module counter_clk_down #(
  parameter int SEC_LIMIT = 60,
  parameter int MIN_LIMIT = 60,
  parameter int DW        = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_tick,
  input  logic          i_load,
  input  logic [DW-1:0] i_load_min,
  input  logic [DW-1:0] i_load_sec,
  input  logic          i_start,
  input  logic          i_stop,
  output logic [DW-1:0] o_min,
  output logic [DW-1:0] o_sec,
  output logic          o_run,
  output logic          o_borrow,
  output logic          o_done,
  output logic [1:0]    o_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [DW-1:0] SEC_MAX = DW'(SEC_LIMIT - 1);
  localparam logic [DW-1:0] MIN_MAX = DW'(MIN_LIMIT - 1);
  localparam logic [DW-1:0] ZERO    = '0;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] min_q, min_d;
  logic [DW-1:0] sec_q, sec_d;
  logic          borrow_q, borrow_d;
  logic          done_q, done_d;

  logic          count_zero;
  assign count_zero = (min_q == ZERO) && (sec_q == ZERO);

  // Control inputs are single-cycle strobes sampled on the edge; the
  // if/else chain below encodes their priority: load, stop, start, tick.
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;
    if (i_load) begin
      min_d   = (i_load_min > MIN_MAX) ? MIN_MAX : i_load_min;
      sec_d   = (i_load_sec > SEC_MAX) ? SEC_MAX : i_load_sec;
      state_d = ST_IDLE;
    end else if (i_stop) begin
      if (state_q == ST_RUN) begin
        state_d = ST_PAUSE;
      end
    end else if (i_start) begin
      if ((state_q == ST_IDLE || state_q == ST_PAUSE) && !count_zero) begin
        state_d = ST_RUN;
      end
    end else if (i_tick && state_q == ST_RUN) begin
      if (sec_q != ZERO) begin
        sec_d = sec_q - 1'b1;
      end else if (min_q != ZERO) begin
        sec_d    = SEC_MAX;
        min_d    = min_q - 1'b1;
        borrow_d = 1'b1;
      end
      // Completion is judged on the post-tick value so o_done lines up with it.
      if (min_d == ZERO && sec_d == ZERO) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      min_q    <= '0;
      sec_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign o_min    = min_q;
  assign o_sec    = sec_q;
  assign o_run    = (state_q == ST_RUN);
  assign o_borrow = borrow_q;
  assign o_done   = done_q;
  assign o_state  = state_q;

endmodule

// File: tb/tb_counter_clk_down.sv
// Directed bench for counter_clk_down; fields are 7 bits wide so that a
// 63:70 load can present both fields out of range.
module tb_counter_clk_down;

  localparam int DW = 7;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic          clk;
  logic          rst;
  logic          i_tick, i_load, i_start, i_stop;
  logic [DW-1:0] i_load_min, i_load_sec;
  logic [DW-1:0] o_min, o_sec;
  logic          o_run, o_borrow, o_done;
  logic [1:0]    o_state;

  int n_checks = 0;
  int n_pass   = 0;

  counter_clk_down #(.SEC_LIMIT(60), .MIN_LIMIT(60), .DW(DW)) dut (
    .clk(clk), .rst(rst), .i_tick(i_tick), .i_load(i_load),
    .i_load_min(i_load_min), .i_load_sec(i_load_sec),
    .i_start(i_start), .i_stop(i_stop),
    .o_min(o_min), .o_sec(o_sec), .o_run(o_run),
    .o_borrow(o_borrow), .o_done(o_done), .o_state(o_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Apply current inputs across one edge, sample 1 time unit later, clear strobes.
  task automatic cycle();
    @(posedge clk);
    #1;
    i_tick  = 1'b0;
    i_load  = 1'b0;
    i_start = 1'b0;
    i_stop  = 1'b0;
  endtask

  task automatic load(input int m, input int s);
    i_load     = 1'b1;
    i_load_min = DW'(m);
    i_load_sec = DW'(s);
    cycle();
  endtask

  task automatic start();
    i_start = 1'b1;
    cycle();
  endtask

  task automatic tick();
    i_tick = 1'b1;
    cycle();
  endtask

  task automatic expect_all(input string tag, input int m, input int s,
                            input logic [1:0] st, input logic run,
                            input logic brw, input logic dn);
    check({tag, ".min"},    32'(o_min),    32'(m));
    check({tag, ".sec"},    32'(o_sec),    32'(s));
    check({tag, ".state"},  32'(o_state),  32'(st));
    check({tag, ".run"},    32'(o_run),    32'(run));
    check({tag, ".borrow"}, 32'(o_borrow), 32'(brw));
    check({tag, ".done"},   32'(o_done),   32'(dn));
  endtask

  initial begin
    rst = 1'b0; i_tick = 0; i_load = 0; i_start = 0; i_stop = 0;
    i_load_min = '0; i_load_sec = '0;
    #1;
    cycle();
    cycle();
    expect_all("reset", 0, 0, IDLE, 0, 0, 0);
    rst = 1'b1;

    // 01:30 -> one tick -> 01:29
    load(1, 30);
    expect_all("load130", 1, 30, IDLE, 0, 0, 0);
    start();
    expect_all("start130", 1, 30, RUN, 1, 0, 0);
    tick();
    expect_all("tick129", 1, 29, RUN, 1, 0, 0);

    // 01:00 borrow, then run to completion
    load(1, 0);
    start();
    tick();
    expect_all("borrow", 0, 59, RUN, 1, 1, 0);
    cycle();
    expect_all("borrow_end", 0, 59, RUN, 1, 0, 0);
    for (int i = 0; i < 58; i++) tick();
    expect_all("at0001", 0, 1, RUN, 1, 0, 0);
    tick();
    expect_all("done", 0, 0, DONE, 0, 0, 1);
    cycle();
    expect_all("done_end", 0, 0, DONE, 0, 0, 0);

    // DONE ignores ticks and start
    tick();
    expect_all("done_tick", 0, 0, DONE, 0, 0, 0);
    start();
    expect_all("done_start", 0, 0, DONE, 0, 0, 0);

    // clamping and zero start
    load(63, 70);
    expect_all("clamp", 59, 59, IDLE, 0, 0, 0);
    load(0, 0);
    start();
    expect_all("zero_start", 0, 0, IDLE, 0, 0, 0);

    // pause behaviour and stop/start priority
    load(0, 10);
    start();
    i_stop = 1'b1; i_tick = 1'b1;
    cycle();
    expect_all("stop_tick", 0, 10, PAUSE, 0, 0, 0);
    i_start = 1'b1; i_stop = 1'b1;
    cycle();
    expect_all("start_stop", 0, 10, PAUSE, 0, 0, 0);
    tick();
    expect_all("pause_tick", 0, 10, PAUSE, 0, 0, 0);
    start();
    expect_all("resume", 0, 10, RUN, 1, 0, 0);
    tick();
    expect_all("resume_tick", 0, 9, RUN, 1, 0, 0);

    // load wins over start/tick while running
    i_load = 1'b1; i_load_min = DW'(2); i_load_sec = DW'(3);
    i_start = 1'b1; i_tick = 1'b1;
    cycle();
    expect_all("load_prio", 2, 3, IDLE, 0, 0, 0);

    // back-to-back ticks to completion
    load(0, 2);
    start();
    tick();
    expect_all("b2b_1", 0, 1, RUN, 1, 0, 0);
    tick();
    expect_all("b2b_0", 0, 0, DONE, 0, 0, 1);

    // reset mid-count together with a tick
    load(0, 5);
    start();
    tick();
    tick();
    expect_all("pre_rst", 0, 3, RUN, 1, 0, 0);
    rst = 1'b0; i_tick = 1'b1;
    cycle();
    rst = 1'b1;
    expect_all("mid_rst", 0, 0, IDLE, 0, 0, 0);
    tick();
    tick();
    expect_all("post_rst", 0, 0, IDLE, 0, 0, 0);

    // reset on the final tick suppresses done
    load(0, 1);
    start();
    rst = 1'b0; i_tick = 1'b1;
    cycle();
    rst = 1'b1;
    expect_all("rst_final", 0, 0, IDLE, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
